// File: rtl/bullet_pool_arbiter.sv
// bullet_pool_arbiter
//   Shared pool of bullet slots for the player tank (requester 0) and the AI
//   tanks. Fire requests are granted round-robin, at most one per Clk. A grant
//   needs the requester's cooldown to be zero, a valid direction and a free
//   slot. Once per frame tick every active bullet moves STEP pixels, and is
//   freed instead if the move would take it off screen. The collision logic
//   can free a slot at any time through hit_clear.
//
//   Optional build macro BULLET_ARB_ONE_PER_OWNER_EN: when defined, a
//   requester that already owns an active slot is not eligible, so each tank
//   has at most one bullet in flight.
//
// Ports
//   Clk, Reset          system clock; synchronous active-high reset
//   frame_clk           ~60 Hz frame clock, edge-detected internally
//   fire_req            level fire request per requester
//   req_x, req_y        requester tank positions, 10 bits per requester
//   req_dir             requester direction, 3 bits each (1 up 2 right 3 left 4 down)
//   hit_clear           frees slot s (ignored for inactive slots)
//   DrawX, DrawY        pixel currently being drawn
//   fire_grant          one-cycle grant pulse per requester
//   slot_active         per-slot valid
//   slot_x, slot_y      per-slot bullet position, 10 bits per slot
//   slot_owner          per-slot owning requester, OW bits per slot
//   is_bullet           current pixel lies in an active bullet
//   bullet_owner        owner of the lowest-index matching slot, 0 otherwise
module bullet_pool_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_SLOTS   = 4,
  parameter int COOLDOWN    = 30,
  parameter int STEP        = 4,
  parameter int SPAWN_OFS   = 16,
  parameter int BULLET_SIZE = 4,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_clk,
  input  logic [NUM_REQ-1:0]        fire_req,
  input  logic [NUM_REQ*10-1:0]     req_x,
  input  logic [NUM_REQ*10-1:0]     req_y,
  input  logic [NUM_REQ*3-1:0]      req_dir,
  input  logic [NUM_SLOTS-1:0]      hit_clear,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  output logic [NUM_REQ-1:0]        fire_grant,
  output logic [NUM_SLOTS-1:0]      slot_active,
  output logic [NUM_SLOTS*10-1:0]   slot_x,
  output logic [NUM_SLOTS*10-1:0]   slot_y,
  output logic [NUM_SLOTS*OW-1:0]   slot_owner,
  output logic                      is_bullet,
  output logic [OW-1:0]             bullet_owner
);

  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                 frame_d1_q, frame_d1_d;
  logic                 frame_tick_q, frame_tick_d;
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [9:0]           x_q     [NUM_SLOTS];
  logic [9:0]           x_d     [NUM_SLOTS];
  logic [9:0]           y_q     [NUM_SLOTS];
  logic [9:0]           y_d     [NUM_SLOTS];
  logic [2:0]           dir_q   [NUM_SLOTS];
  logic [2:0]           dir_d   [NUM_SLOTS];
  logic [OW-1:0]        owner_q [NUM_SLOTS];
  logic [OW-1:0]        owner_d [NUM_SLOTS];
  logic [CW-1:0]        cd_q    [NUM_REQ];
  logic [CW-1:0]        cd_d    [NUM_REQ];
  logic [OW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   fire_grant_q, fire_grant_d;

  // Arbitration signals
  logic                 free_any;
  logic [SW-1:0]        free_idx;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   owns;
  logic                 grant_any;
  logic [OW-1:0]        grant_idx;
  logic [9:0]           sel_x, sel_y;
  logic [2:0]           sel_dir;

  // Free-slot search and round-robin pick, all from registered state so a
  // slot released this cycle only becomes usable next cycle.
  always_comb begin
    int idx;
    logic [2:0] d;
    idx       = 0;
    d         = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    owns      = '0;
    eligible  = '0;
    grant_any = 1'b0;
    grant_idx = '0;

    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!active_q[s]) begin
        free_any = 1'b1;
        free_idx = SW'(s);
      end
    end

`ifdef BULLET_ARB_ONE_PER_OWNER_EN
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (active_q[s]) owns[owner_q[s]] = 1'b1;
    end
`endif

    for (int i = 0; i < NUM_REQ; i++) begin
      d = req_dir[3*i +: 3];
      eligible[i] = fire_req[i] && (cd_q[i] == '0) && (d != 3'd0) &&
                    (d <= 3'd4) && free_any && !owns[i];
    end

    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = OW'(idx);
      end
    end
  end

  always_comb begin
    sel_x   = req_x[10*grant_idx +: 10];
    sel_y   = req_y[10*grant_idx +: 10];
    sel_dir = req_dir[3*grant_idx +: 3];
  end

  // Next-state: frame edge, grant, cooldowns and per-slot update
  always_comb begin
    logic [10:0] x11, y11;
    x11          = '0;
    y11          = '0;
    frame_d1_d   = frame_clk;
    frame_tick_d = frame_clk & ~frame_d1_q;
    fire_grant_d = '0;
    rr_ptr_d     = rr_ptr_q;

    if (grant_any) begin
      fire_grant_d[grant_idx] = 1'b1;
      rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + OW'(1);
    end

    // A fresh grant reloads the full cooldown even on a tick cycle.
    for (int i = 0; i < NUM_REQ; i++) begin
      cd_d[i] = cd_q[i];
      if (grant_any && grant_idx == OW'(i))
        cd_d[i] = CW'(COOLDOWN);
      else if (frame_tick_q && cd_q[i] != '0)
        cd_d[i] = cd_q[i] - CW'(1);
    end

    // Per slot: load > hit_clear > motion/free > hold. The load target is
    // always an inactive slot, so hit_clear on it is ignored anyway.
    for (int s = 0; s < NUM_SLOTS; s++) begin
      active_d[s] = active_q[s];
      x_d[s]      = x_q[s];
      y_d[s]      = y_q[s];
      dir_d[s]    = dir_q[s];
      owner_d[s]  = owner_q[s];
      x11         = {1'b0, x_q[s]};
      y11         = {1'b0, y_q[s]};
      if (grant_any && free_idx == SW'(s)) begin
        active_d[s] = 1'b1;
        x_d[s]      = sel_x + 10'(SPAWN_OFS);
        y_d[s]      = sel_y + 10'(SPAWN_OFS);
        dir_d[s]    = sel_dir;
        owner_d[s]  = grant_idx;
      end else if (hit_clear[s] && active_q[s]) begin
        active_d[s] = 1'b0;
      end else if (frame_tick_q && active_q[s]) begin
        // 11-bit compares so the off-screen test cannot wrap.
        case (dir_q[s])
          3'd1: if (y11 < 11'(STEP)) active_d[s] = 1'b0;
                else y_d[s] = y_q[s] - 10'(STEP);
          3'd2: if (x11 + 11'(STEP) > 11'(X_MAX)) active_d[s] = 1'b0;
                else x_d[s] = x_q[s] + 10'(STEP);
          3'd3: if (x11 < 11'(STEP)) active_d[s] = 1'b0;
                else x_d[s] = x_q[s] - 10'(STEP);
          3'd4: if (y11 + 11'(STEP) > 11'(Y_MAX)) active_d[s] = 1'b0;
                else y_d[s] = y_q[s] + 10'(STEP);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_d1_q   <= 1'b0;
      frame_tick_q <= 1'b0;
      active_q     <= '0;
      rr_ptr_q     <= '0;
      fire_grant_q <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        x_q[s]     <= '0;
        y_q[s]     <= '0;
        dir_q[s]   <= '0;
        owner_q[s] <= '0;
      end
      for (int i = 0; i < NUM_REQ; i++) cd_q[i] <= '0;
    end else begin
      frame_d1_q   <= frame_d1_d;
      frame_tick_q <= frame_tick_d;
      active_q     <= active_d;
      rr_ptr_q     <= rr_ptr_d;
      fire_grant_q <= fire_grant_d;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        x_q[s]     <= x_d[s];
        y_q[s]     <= y_d[s];
        dir_q[s]   <= dir_d[s];
        owner_q[s] <= owner_d[s];
      end
      for (int i = 0; i < NUM_REQ; i++) cd_q[i] <= cd_d[i];
    end
  end

  // Render hit test; descending scan so the lowest-index match wins.
  always_comb begin
    logic signed [10:0] dx, dy;
    dx           = '0;
    dy           = '0;
    is_bullet    = 1'b0;
    bullet_owner = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      dx = $signed({1'b0, DrawX}) - $signed({1'b0, x_q[s]});
      dy = $signed({1'b0, DrawY}) - $signed({1'b0, y_q[s]});
      if (active_q[s] && dx >= 0 && dx < $signed(11'(BULLET_SIZE)) &&
          dy >= 0 && dy < $signed(11'(BULLET_SIZE))) begin
        is_bullet    = 1'b1;
        bullet_owner = owner_q[s];
      end
    end
  end

  always_comb begin
    fire_grant  = fire_grant_q;
    slot_active = active_q;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      slot_x[10*s +: 10]     = x_q[s];
      slot_y[10*s +: 10]     = y_q[s];
      slot_owner[OW*s +: OW] = owner_q[s];
    end
  end

endmodule

// File: tb/tb_bullet_pool_arbiter.sv
module tb_bullet_pool_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [3:0]  fire_req;
  logic [39:0] req_x, req_y;
  logic [11:0] req_dir;
  logic [3:0]  hit_clear;
  logic [9:0]  DrawX, DrawY;
  logic [3:0]  fire_grant;
  logic [3:0]  slot_active;
  logic [39:0] slot_x, slot_y;
  logic [7:0]  slot_owner;
  logic        is_bullet;
  logic [1:0]  bullet_owner;

  int checks   = 0;
  int failures = 0;
  logic [3:0] seen;

  bullet_pool_arbiter dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .fire_req     (fire_req),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_dir      (req_dir),
    .hit_clear    (hit_clear),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .fire_grant   (fire_grant),
    .slot_active  (slot_active),
    .slot_x       (slot_x),
    .slot_y       (slot_y),
    .slot_owner   (slot_owner),
    .is_bullet    (is_bullet),
    .bullet_owner (bullet_owner)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One frame_clk pulse; the registered tick acts on the second edge.
  task automatic tick();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  task automatic set_req(input int i, input logic [9:0] x, input logic [9:0] y,
                         input logic [2:0] d);
    req_x[10*i +: 10] = x;
    req_y[10*i +: 10] = y;
    req_dir[3*i +: 3] = d;
  endtask

  initial begin
    Reset     = 1'b1;
    frame_clk = 1'b0;
    fire_req  = '0;
    req_x     = '0;
    req_y     = '0;
    req_dir   = '0;
    hit_clear = '0;
    DrawX     = '0;
    DrawY     = '0;
    step();
    step();
    chk("reset_active", slot_active, 4'b0000);
    chk("reset_grant", fire_grant, 4'b0000);
    chk("reset_slot_x", slot_x, 40'd0);
    chk("reset_is_bullet", is_bullet, 1'b0);

    // Single fire into an empty pool
    Reset = 1'b0;
    set_req(0, 10'd100, 10'd380, 3'd1);
    fire_req = 4'b0001;
    step();
    chk("t1_grant", fire_grant, 4'b0001);
    chk("t1_active", slot_active, 4'b0001);
    chk("t1_x", slot_x[9:0], 10'd116);
    chk("t1_y", slot_y[9:0], 10'd396);
    chk("t1_owner", slot_owner[1:0], 2'd0);
    fire_req = '0;
    step();
    chk("t1_grant_pulse", fire_grant, 4'b0000);
    DrawX = 10'd117; DrawY = 10'd399; #1;
    chk("render_in", is_bullet, 1'b1);
    DrawX = 10'd120; #1;
    chk("render_right_edge", is_bullet, 1'b0);
    DrawX = 10'd115; #1;
    chk("render_left_edge", is_bullet, 1'b0);
    tick();
    chk("t1_move_y", slot_y[9:0], 10'd392);
    chk("t1_move_x", slot_x[9:0], 10'd116);

    // Round-robin from rr_ptr=0
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    set_req(1, 10'd200, 10'd200, 3'd2);
    set_req(2, 10'd400, 10'd300, 3'd2);
    fire_req = 4'b0011;
    step();
    chk("rr_grant0", fire_grant, 4'b0001);
    chk("rr_slot0", slot_active, 4'b0001);
    step();
    chk("rr_grant1", fire_grant, 4'b0010);
    chk("rr_slot1", slot_active, 4'b0011);
    chk("rr_slot1_x", slot_x[19:10], 10'd216);
    chk("rr_slot1_owner", slot_owner[3:2], 2'd1);
    step();
    chk("rr_cool_a", fire_grant, 4'b0000);
    step();
    step();
    chk("rr_cool_b", fire_grant, 4'b0000);

    // Cooldown: 29 ticks never enough
    seen = '0;
    for (int t = 0; t < 29; t++) begin
      frame_clk = 1'b1;
      step();
      seen = seen | fire_grant;
      frame_clk = 1'b0;
      step();
      seen = seen | fire_grant;
    end
    chk("cd_no_early_grant", seen, 4'b0000);
    frame_clk = 1'b1;
    step();
    chk("cd_tick30_a", fire_grant, 4'b0000);
    frame_clk = 1'b0;
    step();
    chk("cd_tick30_b", fire_grant, 4'b0000);
    chk("cd_slot0_y", slot_y[9:0], 10'd276);
    chk("cd_slot1_x", slot_x[19:10], 10'd336);
    step();
    chk("cd_regrant0", fire_grant, 4'b0001);
    step();
    chk("cd_regrant1", fire_grant, 4'b0010);
    chk("pool_full", slot_active, 4'b1111);

    // Pool full, then one slot freed
    fire_req = 4'b1000;
    set_req(3, 10'd300, 10'd100, 3'd4);
    step();
    chk("full_no_grant_a", fire_grant, 4'b0000);
    step();
    chk("full_no_grant_b", fire_grant, 4'b0000);
    hit_clear = 4'b0100;
    step();
    hit_clear = '0;
    chk("hit_free", slot_active, 4'b1011);
    chk("hit_same_cycle_no_grant", fire_grant, 4'b0000);
    step();
    chk("refill_grant3", fire_grant, 4'b1000);
    chk("refill_active", slot_active, 4'b1111);
    chk("refill_x", slot_x[29:20], 10'd316);
    chk("refill_owner", slot_owner[5:4], 2'd3);
    fire_req = '0;
    DrawX = 10'd317; DrawY = 10'd118; #1;
    chk("render_owner_hit", is_bullet, 1'b1);
    chk("render_owner", bullet_owner, 2'd3);

    // Reset with three bullets in flight
    hit_clear = 4'b1000;
    step();
    hit_clear = '0;
    chk("three_active", slot_active, 4'b0111);
    fire_req = 4'b1111;
    Reset = 1'b1;
    step();
    chk("midreset_active", slot_active, 4'b0000);
    chk("midreset_grant", fire_grant, 4'b0000);
    chk("midreset_x", slot_x, 40'd0);
    chk("midreset_owner", slot_owner, 8'd0);
    Reset = 1'b0;
    step();
    chk("post_reset_grant0", fire_grant, 4'b0001);
    step();
    chk("post_reset_grant1", fire_grant, 4'b0010);
    fire_req = '0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;

    // Screen boundaries and invalid direction
    set_req(2, 10'd620, 10'd50, 3'd2);
    set_req(3, 10'd10, 10'd459, 3'd4);
    fire_req = 4'b0100;
    step();
    chk("bnd_grant2", fire_grant, 4'b0100);
    chk("bnd_x636", slot_x[9:0], 10'd636);
    fire_req = 4'b1000;
    step();
    chk("bnd_grant3", fire_grant, 4'b1000);
    chk("bnd_y475", slot_y[19:10], 10'd475);
    set_req(1, 10'd200, 10'd200, 3'd0);
    fire_req = 4'b0010;
    step();
    chk("bad_dir_no_grant", fire_grant, 4'b0000);
    fire_req = '0;
    tick();
    chk("bnd_right_freed", slot_active, 4'b0010);
    chk("bnd_down_y479", slot_y[19:10], 10'd479);
    tick();
    chk("bnd_down_freed", slot_active, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
